fetch_request_unit: RTL
=======================

# fetch_request_unit

Sequencing front end of the multicycle-memory MIPS datapath. Owns the PC, issues instruction-fetch and data-memory requests, and holds the fetched instruction stable while the control unit decodes it. Consumes the control unit's jump/branch/memory/halt outputs to choose the next PC. Emits a one-cycle commit pulse so architectural state updates exactly once per instruction.

## Interface
- PC_INIT, 32'h0000_0000, PC value loaded on reset

- CLK  in  1  rising-edge clock
- RST  in  1  reset; one clock, synchronous, active-high
- ihit  in  1  instruction memory returns `imemload` this cycle
- imemload  in  32  fetched instruction word
- dhit  in  1  data access completes this cycle
- halt_in  in  1  control unit halt (HALT opcode or overflow)
- Jump  in  2  0 = none, 1 = JR (rs_data), 2 = J/JAL target, 3 = treated as 0
- PCSrc  in  1  0 = branch taken, 1 = sequential
- dREN_in  in  1  control unit data read request
- dWEN_in  in  1  control unit data write request
- rs_data  in  32  register rs value for JR
- instr  out  32  latched instruction driven to decode
- imemaddr  out  32  current PC
- imemREN  out  1  instruction fetch request
- dmemREN  out  1  data read request
- dmemWEN  out  1  data write request
- pc_plus4  out  32  PC + 4, used as the JAL link value
- commit  out  1  one-cycle pulse; instruction retires, gates register-file write
- halt  out  1  sticky halted flag

## Operation
- States:
  - FETCH: imemREN = 1. On ihit, instr <= imemload and go to EXEC.
  - EXEC: decode is valid; inputs are sampled. Priority order:
    - halt_in → HALTED, with no commit and no PC update.
    - else dREN_in | dWEN_in → MEM, latching mem_wr <= dWEN_in (dWEN wins if both are set).
    - else commit = 1, PC <= next_pc, go to FETCH.
  - MEM: dmemWEN = mem_wr and dmemREN = ~mem_wr; both are held until dhit. On dhit, commit = 1, PC <= next_pc, go to FETCH.
  - HALTED: halt = 1 and all requests are 0. PC and instr are frozen. Only RST exits.
- next_pc, computed from the held instruction and current inputs:
  - Jump == 1: {rs_data[31:2], 2'b00}.
  - Jump == 2: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else PCSrc == 0: pc_plus4 + ({{14{instr[15]}}, instr[15:0], 2'b00}), mod 2^32.
  - else pc_plus4.
- pc_plus4 = PC + 4, wrapping 32'hFFFF_FFFC → 0.
- Request outputs are decoded from state only (Moore outputs). imemREN, dmemREN and dmemWEN are never asserted together.
- ihit outside FETCH is ignored. dhit outside MEM is ignored.
- Reset values: PC = PC_INIT, instr = 0, state = FETCH, mem_wr = 0, halt = 0, commit = 0, dmemREN = 0, dmemWEN = 0. imemREN = 1 from the first cycle after reset.

## Timing
- Non-memory instruction: FETCH (1 cycle + ihit wait) + EXEC (1 cycle). Minimum 2 cycles per instruction.
- LW/SW: FETCH + EXEC + MEM (≥1 cycle, held until dhit). Minimum 3 cycles per instruction.
- commit is high during the cycle before the PC edge. The new PC appears on imemaddr the following cycle.
- halt rises the cycle after EXEC samples halt_in, and stays high.
- RST takes priority over ihit, dhit and halt_in in every state. Reset mid-MEM drops dmemREN/dmemWEN the next cycle with no commit.
- JR with unaligned rs_data: the low two bits are forced to 0.

## Test plan
- Reset, ihit held high, addi at PC 0: imemaddr = 0, 0, 4. commit pulses in cycle 2. pc_plus4 = 4.
- BEQ at PC 0x100 with imm16 = 0xFFFF, PCSrc = 0 → next imemaddr = 0x100. Same instruction with PCSrc = 1 → 0x104.
- J at PC 0xF000_0010, target field 0x000_0040 → 0xF000_0100. JR with rs_data = 0x0000_2003 → 0x0000_2000.
- LW with dhit delayed 3 cycles: dmemREN high 3 cycles, imemREN = 0 throughout, commit exactly once on the dhit cycle, PC advances by 4. SW: same sequence with dmemWEN.
- HALT fetched: halt = 1 from the next cycle. Further ihit/dhit pulses cause no PC change and no requests. RST clears halt and PC returns to PC_INIT.
- RST asserted while in MEM with dhit = 0: next cycle state is FETCH, all data requests are 0, commit = 0, PC = PC_INIT.

Source files
------------

// File: rtl/fetch_request_unit.sv
// Multicycle MIPS sequencer: owns the PC, issues fetch/data requests, retires each instruction with a one-cycle commit.
// Two cycles minimum per instruction (three for loads/stores); waits indefinitely on ihit in FETCH and on dhit in MEM.
module fetch_request_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        dhit,
  input  logic        halt_in,
  input  logic [1:0]  Jump,
  input  logic        PCSrc,
  input  logic        dREN_in,
  input  logic        dWEN_in,
  input  logic [31:0] rs_data,
  output logic [31:0] instr,
  output logic [31:0] imemaddr,
  output logic        imemREN,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] pc_plus4,
  output logic        commit,
  output logic        halt
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_MEM    = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        mem_wr_q, mem_wr_d;
  logic [31:0] next_pc;
  logic [31:0] br_off;
  logic        retire;
  logic        unused_rs_lsbs;

  assign unused_rs_lsbs = ^rs_data[1:0];
  assign pc_plus4 = pc_q + 32'd4;
  assign imemaddr = pc_q;
  assign instr    = instr_q;
  assign br_off   = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  always_comb begin
    case (Jump)
      2'd1:    next_pc = {rs_data[31:2], 2'b00};
      2'd2:    next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      default: next_pc = PCSrc ? pc_plus4 : (pc_plus4 + br_off);
    endcase
  end

  // An instruction retires either straight out of EXEC or when its data access completes.
  assign retire = ((state_q == S_EXEC) && !halt_in && !(dREN_in || dWEN_in)) ||
                  ((state_q == S_MEM) && dhit);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_FETCH;
      pc_q     <= PC_INIT;
      instr_q  <= '0;
      mem_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      mem_wr_q <= mem_wr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    mem_wr_d = mem_wr_q;
    case (state_q)
      S_FETCH: begin
        if (ihit) begin
          instr_d = imemload;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (halt_in) begin
          state_d = S_HALTED;
        end else if (dREN_in || dWEN_in) begin
          mem_wr_d = dWEN_in;
          state_d  = S_MEM;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (dhit) state_d = S_FETCH;
      end
      default: state_d = S_HALTED;
    endcase
    if (retire) pc_d = next_pc;
  end

  always_comb begin
    imemREN = (state_q == S_FETCH);
    dmemREN = (state_q == S_MEM) && !mem_wr_q;
    dmemWEN = (state_q == S_MEM) && mem_wr_q;
    halt    = (state_q == S_HALTED);
    commit  = retire && !RST;
  end

endmodule
